// File: rtl/regfile_read_ctrl.sv
// Two-port register-file read sequencer: drives one-hot row enables for one
// cycle, captures both bitlines (with write bypass), then holds the result.
module regfile_read_ctrl #(
   parameter int NUM_REGS = 16,
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   src1_addr,
   input  logic [ADDR_W-1:0]   src2_addr,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   output logic [NUM_REGS-1:0] ren1_word,
   output logic [NUM_REGS-1:0] ren2_word,
   input  logic [WIDTH-1:0]    bitline1,
   input  logic [WIDTH-1:0]    bitline2,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [WIDTH-1:0]    rd_data1,
   output logic [WIDTH-1:0]    rd_data2
);

   typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr1_q, addr1_d;
   logic [ADDR_W-1:0]   addr2_q, addr2_d;
   logic [NUM_REGS-1:0] ren1_q, ren1_d;
   logic [NUM_REGS-1:0] ren2_q, ren2_d;
   logic [WIDTH-1:0]    rd_data1_q, rd_data1_d;
   logic [WIDTH-1:0]    rd_data2_q, rd_data2_d;

   always_comb begin
      state_d    = state_q;
      addr1_d    = addr1_q;
      addr2_d    = addr2_q;
      ren1_d     = '0;
      ren2_d     = '0;
      rd_data1_d = rd_data1_q;
      rd_data2_d = rd_data2_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr1_d = src1_addr;
               addr2_d = src2_addr;
               ren1_d  = NUM_REGS'(1) << src1_addr;
               ren2_d  = NUM_REGS'(1) << src2_addr;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            // a same-cycle write is newer than what the row drives
            rd_data1_d = (wr_en && wr_addr == addr1_q) ? wr_data : bitline1;
            rd_data2_d = (wr_en && wr_addr == addr2_q) ? wr_data : bitline2;
            state_d    = HOLD;
         end
         HOLD: begin
            if (rd_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr1_q    <= '0;
         addr2_q    <= '0;
         ren1_q     <= '0;
         ren2_q     <= '0;
         rd_data1_q <= '0;
         rd_data2_q <= '0;
      end else begin
         state_q    <= state_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
         ren1_q     <= ren1_d;
         ren2_q     <= ren2_d;
         rd_data1_q <= rd_data1_d;
         rd_data2_q <= rd_data2_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rd_valid  = (state_q == HOLD);
   assign ren1_word = ren1_q;
   assign ren2_word = ren2_q;
   assign rd_data1  = rd_data1_q;
   assign rd_data2  = rd_data2_q;

endmodule
